// File: rtl/gray_value_monitor_if.sv
// Bundle of the monitor's data-path signals: Gray sample in, binary events out, status.
// Latency: none (wires only).
// Backpressure: value_rdy from the consumer throttles event delivery.
interface gray_value_monitor_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] read_gray;      // Gray value from the counter
    logic             read_gray_rdy;  // read_gray is valid this cycle
    logic             value_ena;      // event presented and taken this cycle
    logic [WIDTH-1:0] value_v;        // binary value of the event
    logic             value_rdy;      // consumer can accept an event
    logic             clear_ena;      // clear error and dropped
    logic             clear_rdy;      // always ready
    logic             error;          // sticky multi-bit transition flag
    logic [7:0]       dropped;        // events lost to a full FIFO, saturating

    // Monitor side
    modport slave (
        input  read_gray, read_gray_rdy, value_rdy, clear_ena,
        output value_ena, value_v, clear_rdy, error, dropped
    );

    // Counter / consumer / bench side
    modport master (
        output read_gray, read_gray_rdy, value_rdy, clear_ena,
        input  value_ena, value_v, clear_rdy, error, dropped
    );
endinterface

// File: rtl/gray_value_monitor.sv
// Samples a Gray counter, queues each new value (as binary) in a small FIFO, flags illegal jumps.
// Latency: change sampled in cycle n is visible on value_ena/value_v in cycle n+1 at the earliest.
// Backpressure: value_rdy=0 holds the FIFO; changes arriving while full are dropped and counted.
module gray_value_monitor #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  nRST,
    gray_value_monitor_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] last_gray;
    logic             primed;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             error_q;
    logic [7:0]       dropped_q;

    logic             empty;
    logic             full;
    logic             pop;
    logic             chg;
    logic             push;
    logic             drop;
    logic             multi_bit;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] bin;

    // FIFO state: the extra pointer MSB tells a full ring from an empty one
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Pop depends only on FIFO state and consumer ready, never on this cycle's sample
    assign pop  = !empty && bus.value_rdy;
    assign chg  = primed && bus.read_gray_rdy && (bus.read_gray != last_gray);
    // A full FIFO still accepts the event when the head leaves in the same cycle
    assign push = chg && (!full || pop);
    assign drop = chg && full && !pop;

    // A legal Gray step flips exactly one bit; diff is nonzero whenever chg is set
    assign diff      = bus.read_gray ^ last_gray;
    assign multi_bit = (diff & (diff - {{(WIDTH-1){1'b0}}, 1'b1})) != '0;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(bus.read_gray >> i);
        end
    end

    assign bus.value_ena = pop;
    assign bus.value_v   = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign bus.clear_rdy = 1'b1;
    assign bus.error     = error_q;
    assign bus.dropped   = dropped_q;

    // FIFO storage: data only, validity is carried by the pointers
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= bin;
        end
    end

    // Sample tracking and FIFO pointers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_gray <= '0;
            primed    <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            if (bus.read_gray_rdy && !primed) begin
                primed    <= 1'b1;
                last_gray <= bus.read_gray;
            end else if (chg) begin
                last_gray <= bus.read_gray;
            end
            if (push) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Status: clear wins over a same-cycle error or drop, which is then not recorded
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            error_q   <= 1'b0;
            dropped_q <= 8'd0;
        end else if (bus.clear_ena) begin
            error_q   <= 1'b0;
            dropped_q <= 8'd0;
        end else begin
            if (chg && multi_bit) begin
                error_q <= 1'b1;
            end
            if (drop && (dropped_q != 8'hFF)) begin
                dropped_q <= dropped_q + 8'd1;
            end
        end
    end
endmodule
